pd_axis_sequencer: RTL and testbench

//  Time-multiplexes one shared PD math datapath across pitch, roll and yaw. On each new

---
 rtl/pd_axis_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_pd_axis_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pd_axis_sequencer.sv
// Time-multiplexes one shared PD datapath across pitch, roll and yaw for each inertial frame.
// Optional sticky overrun flag (ovr/ovr_clr) is built when PD_SEQ_OVR_EN is defined.
module pd_axis_sequencer #(
  parameter int unsigned PD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic [15:0]        d_ptch,
  input  logic [15:0]        d_roll,
  input  logic [15:0]        d_yaw,
  input  logic [15:0]        ptch,
  input  logic [15:0]        roll,
  input  logic [15:0]        yaw,
  output logic               pd_vld,
  output logic [1:0]         pd_axis,
  output logic [15:0]        pd_desired,
  output logic [15:0]        pd_actual,
  input  logic signed [9:0]  pd_pterm,
  input  logic signed [11:0] pd_dterm,
  output logic signed [9:0]  ptch_pterm,
  output logic signed [11:0] ptch_dterm,
  output logic signed [9:0]  roll_pterm,
  output logic signed [11:0] roll_dterm,
  output logic signed [9:0]  yaw_pterm,
  output logic signed [11:0] yaw_dterm,
`ifdef PD_SEQ_OVR_EN
  output logic               ovr,
  input  logic               ovr_clr,
`endif
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] LatCnt = 3'(PD_LAT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic               w_accept;
  logic               w_capture;
  logic               w_last;
  logic [15:0]        w_next_des;
  logic [15:0]        w_next_act;

  logic [2:0]         r_cnt;
  logic [1:0]         r_axis;
  logic               r_pd_vld;
  logic               r_busy;
  logic               r_done;
  logic [15:0]        r_pd_desired;
  logic [15:0]        r_pd_actual;

  // The pitch pair is held in r_pd_* from acceptance until the roll issue, so only
  // roll and yaw need separate snapshot storage.
  logic [15:0]        r_snap_d_roll;
  logic [15:0]        r_snap_d_yaw;
  logic [15:0]        r_snap_roll;
  logic [15:0]        r_snap_yaw;

  logic signed [9:0]  r_sh_ptch_p;
  logic signed [11:0] r_sh_ptch_d;
  logic signed [9:0]  r_sh_roll_p;
  logic signed [11:0] r_sh_roll_d;

  logic signed [9:0]  r_ptch_p;
  logic signed [11:0] r_ptch_d;
  logic signed [9:0]  r_roll_p;
  logic signed [11:0] r_roll_d;
  logic signed [9:0]  r_yaw_p;
  logic signed [11:0] r_yaw_d;

  assign w_last     = (r_axis == 2'd2);
  assign w_next_des = (r_axis == 2'd0) ? r_snap_d_roll : r_snap_d_yaw;
  assign w_next_act = (r_axis == 2'd0) ? r_snap_roll : r_snap_yaw;

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (vld) begin
          w_accept  = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        w_state_d = StWait;
      end
      StWait: begin
        if (r_cnt == 3'd1) begin
          w_capture = 1'b1;
          w_state_d = w_last ? StDone : StIssue;
        end
      end
      StDone: begin
        w_state_d = StIdle;
        if (vld) begin
          w_accept  = 1'b1;
          w_state_d = StIssue;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= 3'd0;
      r_axis        <= 2'd0;
      r_pd_vld      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pd_desired  <= 16'd0;
      r_pd_actual   <= 16'd0;
      r_snap_d_roll <= 16'd0;
      r_snap_d_yaw  <= 16'd0;
      r_snap_roll   <= 16'd0;
      r_snap_yaw    <= 16'd0;
      r_sh_ptch_p   <= '0;
      r_sh_ptch_d   <= '0;
      r_sh_roll_p   <= '0;
      r_sh_roll_d   <= '0;
      r_ptch_p      <= '0;
      r_ptch_d      <= '0;
      r_roll_p      <= '0;
      r_roll_d      <= '0;
      r_yaw_p       <= '0;
      r_yaw_d       <= '0;
    end else begin
      r_pd_vld <= (w_state_d == StIssue);
      r_busy   <= (w_state_d == StIssue) || (w_state_d == StWait);
      r_done   <= (w_state_d == StDone);

      if (r_state == StIssue) begin
        r_cnt <= LatCnt;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - 3'd1;
      end

      if (w_accept) begin
        r_axis        <= 2'd0;
        r_pd_desired  <= d_ptch;
        r_pd_actual   <= ptch;
        r_snap_d_roll <= d_roll;
        r_snap_d_yaw  <= d_yaw;
        r_snap_roll   <= roll;
        r_snap_yaw    <= yaw;
      end

      if (w_capture) begin
        case (r_axis)
          2'd0: begin
            r_sh_ptch_p <= pd_pterm;
            r_sh_ptch_d <= pd_dterm;
          end
          2'd1: begin
            r_sh_roll_p <= pd_pterm;
            r_sh_roll_d <= pd_dterm;
          end
          default: ;
        endcase

        if (!w_last) begin
          r_axis       <= r_axis + 2'd1;
          r_pd_desired <= w_next_des;
          r_pd_actual  <= w_next_act;
        end else begin
          // Publish on entry to DONE so results and the done pulse appear together;
          // yaw goes straight from the PD result since it is captured on this edge.
          r_ptch_p <= r_sh_ptch_p;
          r_ptch_d <= r_sh_ptch_d;
          r_roll_p <= r_sh_roll_p;
          r_roll_d <= r_sh_roll_d;
          r_yaw_p  <= pd_pterm;
          r_yaw_d  <= pd_dterm;
        end
      end
    end
  end

`ifdef PD_SEQ_OVR_EN
  logic r_ovr;
  logic w_drop;

  assign w_drop = vld && ((r_state == StIssue) || (r_state == StWait));

  // A drop in the same cycle as a clear must still leave the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr <= 1'b0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
    end else if (ovr_clr) begin
      r_ovr <= 1'b0;
    end
  end

  assign ovr = r_ovr;
`endif

  assign pd_vld     = r_pd_vld;
  assign pd_axis    = r_axis;
  assign pd_desired = r_pd_desired;
  assign pd_actual  = r_pd_actual;
  assign busy       = r_busy;
  assign done       = r_done;
  assign ptch_pterm = r_ptch_p;
  assign ptch_dterm = r_ptch_d;
  assign roll_pterm = r_roll_p;
  assign roll_dterm = r_roll_d;
  assign yaw_pterm  = r_yaw_p;
  assign yaw_dterm  = r_yaw_d;

endmodule

// File: tb/tb_pd_axis_sequencer.sv
// Scoreboard bench for pd_axis_sequencer: one DUT at PD_LAT=1, one at PD_LAT=3, each fed by
// a PD stub returning pterm=pd_actual[9:0], dterm=pd_desired[11:0] after PD_LAT cycles.
module tb_pd_axis_sequencer;

  typedef struct {
    int          cyc;
    logic [1:0]  ax;
    logic [15:0] des;
    logic [15:0] act;
  } iss_t;

  typedef struct {
    int          cyc;
    logic [9:0]  pp;
    logic [11:0] pd;
    logic [9:0]  rp;
    logic [11:0] rd;
    logic [9:0]  yp;
    logic [11:0] yd;
  } done_t;

  logic        clk;
  logic        rst_n;
  logic        vld;
  logic        vld3;
  logic [15:0] d_ptch, d_roll, d_yaw, ptch, roll, yaw;

  logic        pd_vld1, busy1, done1;
  logic [1:0]  pd_axis1;
  logic [15:0] pd_des1, pd_act1;
  logic [9:0]  pt1, ptch_p1, roll_p1, yaw_p1;
  logic [11:0] dt1, ptch_d1, roll_d1, yaw_d1;

  logic        pd_vld3, busy3, done3;
  logic [1:0]  pd_axis3;
  logic [15:0] pd_des3, pd_act3;
  logic [9:0]  pt3, ptch_p3, roll_p3, yaw_p3;
  logic [11:0] dt3, ptch_d3, roll_d3, yaw_d3;

`ifdef PD_SEQ_OVR_EN
  logic        ovr_clr, ovr1, ovr3;
`endif

  int    cyc = 0;
  int    n_checks = 0;
  int    n_errs = 0;
  iss_t  q_iss[$];
  done_t q_done1[$];
  done_t q_done3[$];

  pd_axis_sequencer #(.PD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .vld(vld),
    .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw), .ptch(ptch), .roll(roll), .yaw(yaw),
    .pd_vld(pd_vld1), .pd_axis(pd_axis1), .pd_desired(pd_des1), .pd_actual(pd_act1),
    .pd_pterm(pt1), .pd_dterm(dt1),
    .ptch_pterm(ptch_p1), .ptch_dterm(ptch_d1), .roll_pterm(roll_p1), .roll_dterm(roll_d1),
    .yaw_pterm(yaw_p1), .yaw_dterm(yaw_d1),
`ifdef PD_SEQ_OVR_EN
    .ovr(ovr1), .ovr_clr(ovr_clr),
`endif
    .busy(busy1), .done(done1)
  );

  pd_axis_sequencer #(.PD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .vld(vld3),
    .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw), .ptch(ptch), .roll(roll), .yaw(yaw),
    .pd_vld(pd_vld3), .pd_axis(pd_axis3), .pd_desired(pd_des3), .pd_actual(pd_act3),
    .pd_pterm(pt3), .pd_dterm(dt3),
    .ptch_pterm(ptch_p3), .ptch_dterm(ptch_d3), .roll_pterm(roll_p3), .roll_dterm(roll_d3),
    .yaw_pterm(yaw_p3), .yaw_dterm(yaw_d3),
`ifdef PD_SEQ_OVR_EN
    .ovr(ovr3), .ovr_clr(ovr_clr),
`endif
    .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PD stubs: result is only valid PD_LAT cycles after pd_vld, otherwise a poison pattern.
  logic        s1_v = 1'b0;
  logic [9:0]  s1_p = '0;
  logic [11:0] s1_d = '0;
  always @(posedge clk) begin
    s1_v <= pd_vld1;
    s1_p <= pd_act1[9:0];
    s1_d <= pd_des1[11:0];
  end
  assign pt1 = s1_v ? s1_p : 10'h2AA;
  assign dt1 = s1_v ? s1_d : 12'h555;

  logic        s3_v[3] = '{1'b0, 1'b0, 1'b0};
  logic [9:0]  s3_p[3] = '{10'd0, 10'd0, 10'd0};
  logic [11:0] s3_d[3] = '{12'd0, 12'd0, 12'd0};
  always @(posedge clk) begin
    s3_v[0] <= pd_vld3;
    s3_p[0] <= pd_act3[9:0];
    s3_d[0] <= pd_des3[11:0];
    for (int k = 1; k < 3; k++) begin
      s3_v[k] <= s3_v[k-1];
      s3_p[k] <= s3_p[k-1];
      s3_d[k] <= s3_d[k-1];
    end
  end
  assign pt3 = s3_v[2] ? s3_p[2] : 10'h2AA;
  assign dt3 = s3_v[2] ? s3_d[2] : 12'h555;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int t0, input int lat, input bit to3,
                          input logic [15:0] dp, dr, dy, p, r, y);
    iss_t  i;
    done_t e;
    int    per;
    per = lat + 1;
    if (!to3) begin
      i.cyc = t0 + 1;         i.ax = 2'd0; i.des = dp; i.act = p; q_iss.push_back(i);
      i.cyc = t0 + 1 + per;   i.ax = 2'd1; i.des = dr; i.act = r; q_iss.push_back(i);
      i.cyc = t0 + 1 + 2*per; i.ax = 2'd2; i.des = dy; i.act = y; q_iss.push_back(i);
    end
    e.cyc = t0 + 1 + 3*per;
    e.pp = p[9:0]; e.pd = dp[11:0];
    e.rp = r[9:0]; e.rd = dr[11:0];
    e.yp = y[9:0]; e.yd = dy[11:0];
    if (to3) q_done3.push_back(e);
    else     q_done1.push_back(e);
  endtask

  task automatic issue(input logic [15:0] dp, dr, dy, p, r, y, input bit acc);
    d_ptch = dp; d_roll = dr; d_yaw = dy; ptch = p; roll = r; yaw = y;
    vld = 1'b1;
    if (acc) push_exp(cyc, 1, 1'b0, dp, dr, dy, p, r, y);
    step(1);
    vld = 1'b0;
  endtask

  task automatic issue3(input logic [15:0] dp, dr, dy, p, r, y);
    d_ptch = dp; d_roll = dr; d_yaw = dy; ptch = p; roll = r; yaw = y;
    vld3 = 1'b1;
    push_exp(cyc, 3, 1'b1, dp, dr, dy, p, r, y);
    step(1);
    vld3 = 1'b0;
  endtask

  task automatic check_done(input string tag, input done_t e,
                            input logic [9:0] pp, rp, yp, input logic [11:0] pd, rd, yd);
    chk({tag, "_cycle"}, cyc, e.cyc);
    chk({tag, "_ptch_pterm"}, pp, e.pp);
    chk({tag, "_ptch_dterm"}, pd, e.pd);
    chk({tag, "_roll_pterm"}, rp, e.rp);
    chk({tag, "_roll_dterm"}, rd, e.rd);
    chk({tag, "_yaw_pterm"}, yp, e.yp);
    chk({tag, "_yaw_dterm"}, yd, e.yd);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_pd_vld"}, pd_vld1, 0);
    chk({tag, "_pd_axis"}, pd_axis1, 0);
    chk({tag, "_pd_desired"}, pd_des1, 0);
    chk({tag, "_pd_actual"}, pd_act1, 0);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_pub_p"}, {ptch_p1, roll_p1, yaw_p1}, 0);
    chk({tag, "_pub_d"}, {ptch_d1, roll_d1, yaw_d1}, 0);
    chk({tag, "_busy3"}, busy3, 0);
`ifdef PD_SEQ_OVR_EN
    chk({tag, "_ovr"}, ovr1, 0);
`endif
  endtask

  iss_t  m_i;
  done_t m_d;
  always @(negedge clk) begin
    if (pd_vld1) begin
      if (q_iss.size() == 0) begin
        n_checks++; n_errs++;
        $display("FAIL pd_vld at cycle %0d: got an issue, required none", cyc);
      end else begin
        m_i = q_iss.pop_front();
        chk("issue_cycle", cyc, m_i.cyc);
        chk("pd_axis", pd_axis1, m_i.ax);
        chk("pd_desired", pd_des1, m_i.des);
        chk("pd_actual", pd_act1, m_i.act);
      end
    end
    if (done1) begin
      if (q_done1.size() == 0) begin
        n_checks++; n_errs++;
        $display("FAIL done at cycle %0d: got a done pulse, required none", cyc);
      end else begin
        m_d = q_done1.pop_front();
        check_done("lat1", m_d, ptch_p1, roll_p1, yaw_p1, ptch_d1, roll_d1, yaw_d1);
      end
    end
    if (done3) begin
      if (q_done3.size() == 0) begin
        n_checks++; n_errs++;
        $display("FAIL done3 at cycle %0d: got a done pulse, required none", cyc);
      end else begin
        m_d = q_done3.pop_front();
        check_done("lat3", m_d, ptch_p3, roll_p3, yaw_p3, ptch_d3, roll_d3, yaw_d3);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vld = 1'b0; vld3 = 1'b0;
    d_ptch = '0; d_roll = '0; d_yaw = '0; ptch = '0; roll = '0; yaw = '0;
`ifdef PD_SEQ_OVR_EN
    ovr_clr = 1'b0;
`endif
    step(2);
    check_idle("reset");
    rst_n = 1'b1;
    step(2);

    // Basic frame: issues at +1/+3/+5, done at +7.
    issue(16'h0010, 16'h0020, 16'h0030, 16'd5, 16'd6, 16'd7, 1'b1);
    chk("busy_first_issue", busy1, 1);
    step(6);
    chk("busy_in_done", busy1, 0);
    chk("done_at_7", done1, 1);
    step(3);

    // Inputs zeroed mid-frame must not disturb the snapshot; also checks truncation.
    issue(16'hABCD, 16'h0AAA, 16'h8001, 16'h1234, 16'h0155, 16'hFFFF, 1'b1);
    step(1);
    d_ptch = '0; d_roll = '0; d_yaw = '0; ptch = '0; roll = '0; yaw = '0;
    step(8);

    // Negative results pass through with sign bits intact.
    issue(16'h0FC8, 16'h0800, 16'h07FF, 16'h03FB, 16'h0200, 16'h0001, 1'b1);
    step(8);

    // vld in the done cycle starts the next frame with no gap.
    issue(16'h0010, 16'h0020, 16'h0030, 16'd5, 16'd6, 16'd7, 1'b1);
    step(6);
    issue(16'h0111, 16'h0222, 16'h0333, 16'h0044, 16'h0055, 16'h0066, 1'b1);
    chk("busy_back_to_back", busy1, 1);
    step(8);

    // vld while busy is dropped.
    issue(16'h0101, 16'h0202, 16'h0303, 16'h0011, 16'h0022, 16'h0033, 1'b1);
    step(2);
    issue(16'h0EEE, 16'h0DDD, 16'h0CCC, 16'h0BBB, 16'h0AAA, 16'h0999, 1'b0);
`ifdef PD_SEQ_OVR_EN
    chk("ovr_set", ovr1, 1);
`endif
    step(3);
`ifdef PD_SEQ_OVR_EN
    chk("ovr_sticky", ovr1, 1);
`endif
    step(2);
`ifdef PD_SEQ_OVR_EN
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    chk("ovr_cleared", ovr1, 0);
    issue(16'h0010, 16'h0020, 16'h0030, 16'd5, 16'd6, 16'd7, 1'b1);
    ovr_clr = 1'b1;
    issue(16'h0EEE, 16'h0DDD, 16'h0CCC, 16'h0BBB, 16'h0AAA, 16'h0999, 1'b0);
    ovr_clr = 1'b0;
    chk("ovr_set_wins", ovr1, 1);
    step(8);
`endif

    // Reset mid-frame discards the frame with no done.
    issue(16'h0123, 16'h0456, 16'h0789, 16'h0012, 16'h0034, 16'h0056, 1'b1);
    step(3);
    rst_n = 1'b0;
    q_iss.delete();
    q_done1.delete();
    #1;
    check_idle("midreset");
    step(2);
    chk("no_done_in_reset", done1, 0);
    rst_n = 1'b1;
    step(4);
    issue(16'h0010, 16'h0020, 16'h0030, 16'd5, 16'd6, 16'd7, 1'b1);
    step(9);

    // PD_LAT=3 instance: done at +13.
    issue3(16'h0010, 16'h0020, 16'h0030, 16'd5, 16'd6, 16'd7);
    step(15);

    for (int i = 0; i < 100; i++) begin
      if (q_iss.size() == 0 && q_done1.size() == 0 && q_done3.size() == 0) break;
      step(1);
    end
    if (q_iss.size() != 0 || q_done1.size() != 0 || q_done3.size() != 0) begin
      n_errs++;
      $display("FAIL drain: got %0d issues, %0d/%0d dones still pending, required 0",
               q_iss.size(), q_done1.size(), q_done3.size());
    end
    n_checks++;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
